// File: rtl/l3_sequencer.sv
// Purpose : instruction initiator for the lab-3 datapath controller; steps a
//           small {opcode, data} program through the execute/operation handshake.
// Latency : execute rises on the 3rd rising edge counting the one that samples start
//           (IDLE -> FETCH -> ISSUE -> request). Each later word takes FETCH + ISSUE +
//           the controller's DONE/IDLE handshake + one NEXT cycle.
// Backpres: the sequencer stalls in WAIT_DONE / WAIT_IDLE until the controller
//           answers. It gives up after TIMEOUT cycles and parks in ERR.
//
// Ports   : clk, reset (sync, active-high)
//           prog_we/prog_addr/prog_wdata - program load, ignored while busy
//           prog_len   - index of the last word to run, read live in S_NEXT
//           start      - level, begins a run from address 0 in IDLE or HALT
//           step       - single-step advance (SEQ_SINGLE_STEP_EN builds only)
//           ctrl_state - controller state (IDLE=4'b0000, DONE=4'b1000)
//           execute/operation/data_out - request, opcode and data to the datapath
//           pc, busy, prog_done, err  - run status
//
// Build option: define SEQ_SINGLE_STEP_EN to make S_NEXT wait for step=1.
//               When it is undefined, step is present but unused.

module l3_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int DATA_W     = 4,
    parameter int TIMEOUT    = 64,
    parameter int AW         = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W+2:0] prog_wdata,
    input  logic [AW-1:0]     prog_len,
    input  logic              start,
    input  logic              step,
    input  logic [3:0]        ctrl_state,
    output logic              execute,
    output logic [2:0]        operation,
    output logic [DATA_W-1:0] data_out,
    output logic [AW-1:0]     pc,
    output logic              busy,
    output logic              prog_done,
    output logic              err
);

    localparam int IW = DATA_W + 3;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [3:0] CTRL_IDLE = 4'b0000;
    localparam logic [3:0] CTRL_DONE = 4'b1000;
    // Opcode 101 is reserved by the controller; in a program it terminates the run.
    localparam logic [2:0] OP_HALT   = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_WAIT_IDLE,
        S_NEXT,
        S_HALT,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              exec_q, exec_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Program store. It has no reset, so a loaded program survives a reset.
    logic [IW-1:0]     mem [PROG_DEPTH];
    logic [IW-1:0]     instr_q;
    logic [2:0]        instr_op;
    logic [DATA_W-1:0] instr_dat;

    assign instr_op  = instr_q[IW-1:DATA_W];
    assign instr_dat = instr_q[DATA_W-1:0];

    // Advance qualifier for S_NEXT.
    logic step_ok;
`ifdef SEQ_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
    logic unused_step;
    assign unused_step = step;
`endif

    // A write and a fetch can never collide: fetches happen only while busy,
    // and writes are accepted only while idle.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) begin
            mem[prog_addr] <= prog_wdata;
        end
        if (state_q == S_FETCH) begin
            instr_q <= mem[pc_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            exec_q  <= 1'b0;
            op_q    <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            exec_q  <= exec_d;
            op_q    <= op_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        exec_d  = exec_q;
        op_d    = op_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_ISSUE;
            end

            S_ISSUE: begin
                if (instr_op == OP_HALT) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    exec_d  = 1'b1;
                    op_d    = instr_op;
                    data_d  = instr_dat;
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end
            end

            // DONE is tested before the timeout, so DONE arriving on the last
            // counted cycle still counts as success.
            S_WAIT_DONE: begin
                if (ctrl_state == CTRL_DONE) begin
                    exec_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    exec_d  = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_IDLE: begin
                if (ctrl_state == CTRL_IDLE) begin
                    state_d = S_NEXT;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // prog_len is read live here. The end test comes before the
            // increment, so pc never wraps past the last word.
            S_NEXT: begin
                if (step_ok) begin
                    if (pc_q == prog_len) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end

            S_HALT: begin
                if (start) begin
                    done_d  = 1'b0;
                    pc_d    = '0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_ERR: begin
                // Terminal until reset; start is deliberately ignored.
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign execute   = exec_q;
    assign operation = op_q;
    assign data_out  = data_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign prog_done = done_q;
    assign err       = err_q;

endmodule
